// File: rtl/attention_pkg.sv
// Shared widths, S5.10 constants and FSM encoding for the attention path.
// Imported by qk_row_packer and score_condition.
package attention_pkg;

    localparam int Q5_10_W   = 16;
    localparam int ROW_LANES = 64;
    localparam int ROW_W     = 1024;
    localparam int COL_W     = 6;

    localparam logic [Q5_10_W-1:0] CLAMP_HI_DEF = 16'h3FFF;
    localparam logic [Q5_10_W-1:0] CLAMP_LO_DEF = 16'hC400;
    localparam logic [Q5_10_W-1:0] MASK_VAL_DEF = 16'hC000;

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        WAIT_CLR = 2'd1,
        RUN      = 2'd2,
        OUT      = 2'd3
    } pk_state_e;

endpackage

// File: rtl/score_condition.sv
// Single-lane conditioning: arithmetic scale shift, saturation, causal mask.
// Ports: score_in/col/row_idx/causal_en in, lane_out S5.10 out (combinational).
module score_condition
    import attention_pkg::*;
#(
    parameter int                 SCALE_SHIFT = 3,
    parameter logic [Q5_10_W-1:0] CLAMP_HI    = CLAMP_HI_DEF,
    parameter logic [Q5_10_W-1:0] CLAMP_LO    = CLAMP_LO_DEF,
    parameter logic [Q5_10_W-1:0] MASK_VAL    = MASK_VAL_DEF
) (
    input  logic [Q5_10_W-1:0] score_in,
    input  logic [COL_W-1:0]   col,
    input  logic [COL_W-1:0]   row_idx,
    input  logic               causal_en,
    output logic [Q5_10_W-1:0] lane_out
);

    logic signed [Q5_10_W-1:0] shifted;

    always_comb begin
        shifted = $signed(score_in) >>> SCALE_SHIFT;
        // Mask value sits below CLAMP_LO so masked lanes never win the row max.
        if (causal_en && (col > row_idx)) begin
            lane_out = MASK_VAL;
        end else if (shifted > $signed(CLAMP_HI)) begin
            lane_out = CLAMP_HI;
        end else if (shifted < $signed(CLAMP_LO)) begin
            lane_out = CLAMP_LO;
        end else begin
            lane_out = shifted;
        end
    end

endmodule

// File: rtl/qk_row_packer.sv
// Packs 64 conditioned Q.K^T scores into a row for softmax, captures result.
// Ports: score stream in (valid/ready), softmax start/result, prob row out.
module qk_row_packer
    import attention_pkg::*;
#(
    parameter int                 SCALE_SHIFT = 3,
    parameter logic [Q5_10_W-1:0] CLAMP_HI    = CLAMP_HI_DEF,
    parameter logic [Q5_10_W-1:0] CLAMP_LO    = CLAMP_LO_DEF,
    parameter logic [Q5_10_W-1:0] MASK_VAL    = MASK_VAL_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               causal_en,
    input  logic [COL_W-1:0]   row_idx,
    input  logic [Q5_10_W-1:0] score_in,
    input  logic               score_valid,
    output logic               score_ready,
    output logic [ROW_W-1:0]   sm_qk_input,
    output logic               sm_start,
    input  logic [ROW_W-1:0]   sm_softmax_out,
    input  logic               sm_valid_out,
    output logic [ROW_W-1:0]   prob_out,
    output logic               prob_valid,
    input  logic               prob_ready,
    output logic               busy
);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(ROW_LANES - 1);

    pk_state_e          state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               causal_q, causal_d;
    logic [COL_W-1:0]   row_q, row_d;
    logic [ROW_W-1:0]   qk_q, qk_d;
    logic               start_q, start_d;
    logic [ROW_W-1:0]   prob_q, prob_d;
    logic               pvalid_q, pvalid_d;

    logic               beat;
    logic               eff_causal;
    logic [COL_W-1:0]   eff_row;
    logic [Q5_10_W-1:0] lane;

    assign score_ready = (state_q == FILL);
    assign busy        = (state_q != FILL);
    assign beat        = score_valid && score_ready;
    assign sm_qk_input = qk_q;
    assign sm_start    = start_q;
    assign prob_out    = prob_q;
    assign prob_valid  = pvalid_q;

    // Column 0 uses the live mode inputs; later columns use the values
    // captured with column 0 so the whole row shares one mask setting.
    assign eff_causal = (col_q == '0) ? causal_en : causal_q;
    assign eff_row    = (col_q == '0) ? row_idx   : row_q;

    score_condition #(
        .SCALE_SHIFT (SCALE_SHIFT),
        .CLAMP_HI    (CLAMP_HI),
        .CLAMP_LO    (CLAMP_LO),
        .MASK_VAL    (MASK_VAL)
    ) u_cond (
        .score_in  (score_in),
        .col       (col_q),
        .row_idx   (eff_row),
        .causal_en (eff_causal),
        .lane_out  (lane)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        causal_d = causal_q;
        row_d    = row_q;
        qk_d     = qk_q;
        start_d  = start_q;
        prob_d   = prob_q;
        pvalid_d = pvalid_q;
        unique case (state_q)
            FILL: begin
                if (beat) begin
                    qk_d[{col_q, 4'b0000} +: Q5_10_W] = lane;
                    if (col_q == '0) begin
                        causal_d = causal_en;
                        row_d    = row_idx;
                    end
                    if (col_q == LAST_COL) begin
                        col_d   = '0;
                        state_d = WAIT_CLR;
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
            end
            WAIT_CLR: begin
                // A completion level left over from the last row must
                // drop before a new start is issued.
                if (!sm_valid_out) begin
                    start_d = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sm_valid_out) begin
                    prob_d   = sm_softmax_out;
                    start_d  = 1'b0;
                    pvalid_d = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (prob_ready) begin
                    pvalid_d = 1'b0;
                    state_d  = FILL;
                end
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FILL;
            col_q    <= '0;
            causal_q <= 1'b0;
            row_q    <= '0;
            qk_q     <= '0;
            start_q  <= 1'b0;
            prob_q   <= '0;
            pvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            causal_q <= causal_d;
            row_q    <= row_d;
            qk_q     <= qk_d;
            start_q  <= start_d;
            prob_q   <= prob_d;
            pvalid_q <= pvalid_d;
        end
    end

endmodule

// File: tb/tb_qk_row_packer.sv
// Randomised bench for qk_row_packer with a behavioural row model.
// Two DUTs share stimulus: default shift and a SCALE_SHIFT=0 variant.
module tb_qk_row_packer;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          causal_en = 1'b0;
    logic [5:0]    row_idx = '0;
    logic [15:0]   score_in = '0;
    logic          score_valid = 1'b0;
    logic [1023:0] sm_softmax_out = '0;
    logic          sm_valid_out = 1'b0;
    logic          prob_ready = 1'b0;

    logic          score_ready, sm_start, prob_valid, busy;
    logic [1023:0] sm_qk_input, prob_out;
    logic          score_ready0, sm_start0, prob_valid0, busy0;
    logic [1023:0] sm_qk_input0, prob_out0;

    qk_row_packer dut (
        .clk(clk), .rst(rst), .causal_en(causal_en), .row_idx(row_idx),
        .score_in(score_in), .score_valid(score_valid),
        .score_ready(score_ready), .sm_qk_input(sm_qk_input),
        .sm_start(sm_start), .sm_softmax_out(sm_softmax_out),
        .sm_valid_out(sm_valid_out), .prob_out(prob_out),
        .prob_valid(prob_valid), .prob_ready(prob_ready), .busy(busy)
    );

    qk_row_packer #(.SCALE_SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .causal_en(causal_en), .row_idx(row_idx),
        .score_in(score_in), .score_valid(score_valid),
        .score_ready(score_ready0), .sm_qk_input(sm_qk_input0),
        .sm_start(sm_start0), .sm_softmax_out(sm_softmax_out),
        .sm_valid_out(sm_valid_out), .prob_out(prob_out0),
        .prob_valid(prob_valid0), .prob_ready(prob_ready), .busy(busy0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [1023:0] act,
                       input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] lane_of(input logic [1023:0] r,
                                            input int k);
        return r[k*16 +: 16];
    endfunction

    // Reference conditioning: floor division by 2^shift, clamp, mask.
    function automatic logic [15:0] mcond(input logic [15:0] x,
                                          input int shift, input int col,
                                          input bit c, input int ridx);
        int v, d, s;
        v = int'($signed(x));
        d = 1 << shift;
        if (v >= 0) s = v / d;
        else        s = -((-v + d - 1) / d);
        if (s > 16383)  s = 16383;
        if (s < -15360) s = -15360;
        if (c && col > ridx) s = -16384;
        return 16'(s);
    endfunction

    // Behavioural model: phase flags, expected rows, event cycle stamps.
    bit            m_fill = 1'b1, m_wait = 1'b0;
    bit            m_start = 1'b0, m_pvalid = 1'b0;
    logic [1023:0] m_qk = '0, m_qk0 = '0, m_prob = '0;
    int            beats = 0;
    bit            m_c = 1'b0;
    int            m_r = 0;
    int            cyc = 0, last_beat_cyc = 0, start_cyc = 0;
    logic [1023:0] done_q[$];
    logic [1023:0] mock_q[$];

    always @(negedge clk) begin : model
        bit ce;
        int re;
        chk("score_ready", score_ready, m_fill);
        chk("busy", busy, !m_fill);
        chk("sm_start", sm_start, m_start);
        chk("prob_valid", prob_valid, m_pvalid);
        chk("sm_qk_input", sm_qk_input, m_qk);
        chk("prob_out", prob_out, m_prob);
        chk("ready0", score_ready0, m_fill);
        chk("start0", sm_start0, m_start);
        chk("qk0", sm_qk_input0, m_qk0);
        chk("prob0", prob_out0, m_prob);
        cyc++;
        if (rst) begin
            m_fill = 1; m_wait = 0; m_start = 0; m_pvalid = 0;
            m_qk = '0; m_qk0 = '0; m_prob = '0; beats = 0;
        end else if (m_fill) begin
            if (score_valid) begin
                ce = (beats == 0) ? causal_en : m_c;
                re = (beats == 0) ? int'(row_idx) : m_r;
                if (beats == 0) begin
                    m_c = causal_en;
                    m_r = int'(row_idx);
                end
                m_qk[beats*16 +: 16]  = mcond(score_in, 3, beats, ce, re);
                m_qk0[beats*16 +: 16] = mcond(score_in, 0, beats, ce, re);
                beats++;
                if (beats == 64) begin
                    beats = 0;
                    m_fill = 0;
                    m_wait = 1;
                    last_beat_cyc = cyc;
                end
            end
        end else if (m_wait) begin
            if (!sm_valid_out) begin
                m_wait = 0;
                m_start = 1;
                start_cyc = cyc;
            end
        end else if (m_start) begin
            if (sm_valid_out) begin
                m_start = 0;
                m_pvalid = 1;
                m_prob = sm_softmax_out;
            end
        end else if (m_pvalid) begin
            if (prob_ready) begin
                m_pvalid = 0;
                m_fill = 1;
                done_q.push_back(m_prob);
            end
        end
    end

    // Mock softmax stage and random prob_ready, advanced once per cycle.
    int stale_cnt = 0;
    int mcnt = 0;
    int mlat = 5;
    bit rnd_ready = 1'b0;

    function automatic logic [1023:0] rnd_row();
        logic [1023:0] r;
        for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_ready) prob_ready = 1'($urandom_range(1));
        if (stale_cnt > 0) begin
            sm_valid_out = 1'b1;
            stale_cnt--;
        end else if (sm_start) begin
            if (!sm_valid_out) begin
                mcnt++;
                if (mcnt >= mlat) begin
                    sm_softmax_out = rnd_row();
                    mock_q.push_back(sm_softmax_out);
                    sm_valid_out = 1'b1;
                end
            end
        end else begin
            mcnt = 0;
            sm_valid_out = 1'b0;
        end
    endtask

    function automatic logic [15:0] gen(input int mode, input int k);
        logic [15:0] v;
        v = 16'h0000;
        case (mode)
            0: v = 16'(k * 256);
            1: v = 16'h0400;
            3: v = (k % 2 == 1) ? 16'h8000 : 16'h7FFF;
            default: begin
                case ($urandom_range(3))
                    0: v = 16'($urandom);
                    1: v = 16'h7FFF - 16'($urandom_range(255));
                    2: v = 16'h8000 + 16'($urandom_range(255));
                    default: v = 16'($urandom_range(511)) - 16'd256;
                endcase
            end
        endcase
        return v;
    endfunction

    task automatic send_row(input int mode, input bit c, input logic [5:0] ri,
                            input int gap, input bit stale, input int nb);
        int k;
        int guard;
        k = 0;
        guard = 0;
        while (k < nb && guard < 3000) begin
            if (score_ready) begin
                if (int'($urandom_range(99)) < gap) begin
                    score_valid = 1'b0;
                    score_in = 16'($urandom);
                end else begin
                    score_valid = 1'b1;
                    score_in = gen(mode, k);
                    if (k == 0) begin
                        causal_en = c;
                        row_idx = ri;
                    end else begin
                        causal_en = 1'($urandom_range(1));
                        row_idx = 6'($urandom);
                    end
                    if (stale && k == nb - 1) begin
                        sm_valid_out = 1'b1;
                        sm_softmax_out = rnd_row();
                        stale_cnt = 2;
                    end
                    k++;
                end
            end else begin
                score_valid = 1'($urandom_range(1));
                score_in = 16'($urandom);
            end
            tick();
            guard++;
        end
        score_valid = 1'b0;
        if (k < nb) begin
            checks++;
            failures++;
            $display("FAIL send_row_timeout beats=%0d required=%0d", k, nb);
        end
    endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (!sm_start && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (!sm_start) begin
            failures++;
            $display("FAIL wait_start_timeout sm_start=0 required=1");
        end
    endtask

    task automatic finish_row();
        int n;
        n = 0;
        while (!prob_valid && n < 500) begin
            tick();
            n++;
        end
        checks++;
        if (!prob_valid) begin
            failures++;
            $display("FAIL wait_prob_timeout prob_valid=0 required=1");
        end
        prob_ready = 1'b1;
        tick();
        prob_ready = 1'b0;
    endtask

    logic [1023:0] e;
    int            d0;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_ready", score_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_start", sm_start, 0);
        chk("rst_pvalid", prob_valid, 0);
        chk("rst_qk", sm_qk_input, '0);
        chk("rst_prob", prob_out, '0);

        // Ramp, unmasked, slow downstream.
        mlat = 5;
        send_row(0, 1'b0, 6'd0, 20, 1'b0, 64);
        wait_start();
        for (int k = 0; k < 64; k++) e[k*16 +: 16] = 16'(k * 32);
        chk("ramp_lanes", sm_qk_input, e);
        chk("ramp_start_lat", 1024'(start_cyc - last_beat_cyc), 1);
        while (!prob_valid && mcnt < 50) tick();
        chk("ramp_pvalid", prob_valid, 1);
        chk("ramp_prob", prob_out, mock_q[$]);
        repeat (10) tick();
        chk("hold_prob", prob_out, mock_q[$]);
        chk("hold_pvalid", prob_valid, 1);
        chk("hold_ready", score_ready, 0);
        prob_ready = 1'b1;
        tick();
        prob_ready = 1'b0;
        chk("accept_ready", score_ready, 1);
        chk("accept_pvalid", prob_valid, 0);

        // Causal mask at row 2.
        send_row(1, 1'b1, 6'd2, 10, 1'b0, 64);
        wait_start();
        for (int k = 0; k < 64; k++)
            e[k*16 +: 16] = (k <= 2) ? 16'h0080 : 16'hC000;
        chk("causal_lanes", sm_qk_input, e);
        finish_row();

        // Saturation extremes.
        send_row(3, 1'b0, 6'd0, 0, 1'b0, 64);
        wait_start();
        chk("sat0_hi", lane_of(sm_qk_input0, 0), 16'h3FFF);
        chk("sat0_lo", lane_of(sm_qk_input0, 1), 16'hC400);
        chk("sat3_neg", lane_of(sm_qk_input, 1), 16'hF000);
        chk("sat3_pos", lane_of(sm_qk_input, 0), 16'h0FFF);
        finish_row();

        // Stale completion level at WAIT_CLR entry.
        mlat = 3;
        send_row(2, 1'b1, 6'($urandom), 30, 1'b1, 64);
        wait_start();
        chk("stale_start_lat", 1024'(start_cyc - last_beat_cyc), 3);
        finish_row();

        // Reset after a partial row.
        send_row(2, 1'b0, 6'd0, 0, 1'b0, 30);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_ready", score_ready, 1);
        chk("midrst_busy", busy, 0);
        chk("midrst_qk", sm_qk_input, '0);
        send_row(2, 1'b1, 6'($urandom), 15, 1'b0, 64);
        wait_start();
        chk("midrst_start_lat", 1024'(start_cyc - last_beat_cyc), 1);
        finish_row();

        // Back-to-back rows, downstream always ready.
        prob_ready = 1'b1;
        d0 = done_q.size();
        send_row(2, 1'($urandom_range(1)), 6'($urandom), 0, 1'b0, 64);
        send_row(2, 1'($urandom_range(1)), 6'($urandom), 0, 1'b0, 64);
        for (int n = 0; n < 500 && done_q.size() < d0 + 2; n++) tick();
        chk("b2b_rows", 1024'(done_q.size() - d0), 2);
        prob_ready = 1'b0;

        // Random rows with random backpressure and latency.
        rnd_ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            mlat = int'($urandom_range(1, 8));
            send_row(2, 1'($urandom_range(1)), 6'($urandom), 25,
                     1'($urandom_range(1)), 64);
        end
        rnd_ready = 1'b0;
        prob_ready = 1'b1;
        for (int n = 0; n < 500 && busy; n++) tick();
        chk("drain_busy", busy, 0);
        prob_ready = 1'b0;
        tick();

        chk("row_count", 1024'(done_q.size()), 1024'(mock_q.size()));
        for (int i = 0; i < done_q.size() && i < mock_q.size(); i++)
            chk("row_order", done_q[i], mock_q[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
